// File: rtl/load_store_unit_if.sv
// Data-memory request/ack bus between the load/store unit and memory.
`ifndef XLEN
`define XLEN 32
`endif

interface load_store_unit_if;
  logic              or_mem_req;
  logic [`XLEN-1:0]  or_mem_addr;
  logic [`XLEN-1:0]  or_mem_data;
  logic [2:0]        or_mem_funct3;
  logic              or_mem_read_write;
  logic              i_mem_ack;
  logic [`XLEN-1:0]  i_mem_data;

  // Initiator side: the load/store unit.
  modport master (
    output or_mem_req, or_mem_addr, or_mem_data, or_mem_funct3, or_mem_read_write,
    input  i_mem_ack, i_mem_data
  );

  // Target side: the data memory.
  modport slave (
    input  or_mem_req, or_mem_addr, or_mem_data, or_mem_funct3, or_mem_read_write,
    output i_mem_ack, i_mem_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, rejects illegal or misaligned
// accesses, holds a memory request until ack or timeout, and reports completion.
`ifndef XLEN
`define XLEN 32
`endif

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_is_load,
  input  logic [2:0]        i_funct3,
  input  logic [`XLEN-1:0]  i_base,
  input  logic [`XLEN-1:0]  i_offset,
  input  logic [`XLEN-1:0]  i_store_data,
  load_store_unit_if.master mem,
  output logic              or_busy,
  output logic              or_done,
  output logic [`XLEN-1:0]  or_load_data,
  output logic              or_exc,
  output logic [1:0]        or_exc_code
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TimeoutEn  = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ExcMisaligned = 2'b01;
  localparam logic [1:0] ExcIllegal    = 2'b10;
  localparam logic [1:0] ExcTimeout    = 2'b11;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic [`XLEN-1:0]  w_addr;
  logic              w_legal;
  logic              w_misaligned;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;

  // Decode the operation offered in IDLE and the timeout condition while in REQ.
  always_comb begin
    w_addr  = i_base + i_offset;
    w_legal = 1'b0;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = i_is_load;  // LBU/LHU have no store form
      default:                w_legal = 1'b0;
    endcase
    w_misaligned = ((i_funct3[1:0] == 2'b01) && w_addr[0]) ||
                   ((i_funct3 == 3'b010) && (w_addr[1:0] != 2'b00));
    w_cnt_inc    = r_cnt + 1'b1;
    w_timeout    = TimeoutEn && (w_cnt_inc == TimeoutVal);
  end

  // Sequencer: sample in IDLE, hold the request in REQ, one response cycle in RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state               <= StIdle;
      r_cnt                 <= '0;
      mem.or_mem_req        <= 1'b0;
      mem.or_mem_addr       <= '0;
      mem.or_mem_data       <= '0;
      mem.or_mem_funct3     <= 3'b000;
      mem.or_mem_read_write <= 1'b0;
      or_busy               <= 1'b0;
      or_done               <= 1'b0;
      or_load_data          <= '0;
      or_exc                <= 1'b0;
      or_exc_code           <= 2'b00;
    end else begin
      or_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            mem.or_mem_addr       <= w_addr;
            mem.or_mem_data       <= i_store_data;
            mem.or_mem_funct3     <= i_funct3;
            mem.or_mem_read_write <= i_is_load;
            or_busy               <= 1'b1;
            if (!w_legal || w_misaligned) begin
              // Rejected before memory sees it; illegal funct3 outranks misalignment.
              r_state      <= StResp;
              or_done      <= 1'b1;
              or_exc       <= 1'b1;
              or_exc_code  <= !w_legal ? ExcIllegal : ExcMisaligned;
              or_load_data <= '0;
            end else begin
              r_state        <= StReq;
              mem.or_mem_req <= 1'b1;
              r_cnt          <= '0;
            end
          end
        end
        StReq: begin
          if (mem.i_mem_ack) begin
            // Ack wins even on the cycle the timeout would expire.
            mem.or_mem_req <= 1'b0;
            r_state        <= StResp;
            or_done        <= 1'b1;
            if (mem.or_mem_read_write) begin
              or_load_data <= mem.i_mem_data;
            end
          end else if (w_timeout) begin
            mem.or_mem_req <= 1'b0;
            r_state        <= StResp;
            or_done        <= 1'b1;
            or_exc         <= 1'b1;
            or_exc_code    <= ExcTimeout;
            or_load_data   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StResp: begin
          // Also guarantees a req-low cycle before the next issue.
          r_state     <= StIdle;
          or_busy     <= 1'b0;
          or_exc      <= 1'b0;
          or_exc_code <= 2'b00;
        end
        default: begin
          r_state <= StIdle;
          or_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
